// File: rtl/conv1_pkg.sv
// Shared layer-1 convolution types and constants; pure declarations, no latency.
// Saturation limits match the signed accumulator width consumed by activation.
package conv1_pkg;

  localparam int CONV1_ACC_W  = 20;
  localparam int CONV1_DATA_W = 8;
  localparam int CONV1_TAPS   = 25;

  localparam logic signed [CONV1_ACC_W-1:0] ACC_MAX = {1'b0, {(CONV1_ACC_W-1){1'b1}}};
  localparam logic signed [CONV1_ACC_W-1:0] ACC_MIN = {1'b1, {(CONV1_ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/conv1_sat_add.sv
// Saturating signed add of a product into an accumulator; combinational, zero latency.
// No handshake: ovf reports that the sum was clamped to the accumulator range.
module conv1_sat_add
  import conv1_pkg::*;
#(
  parameter int ACC_W  = CONV1_ACC_W,
  parameter int DATA_W = CONV1_DATA_W
) (
  input  logic signed [ACC_W-1:0]    acc,
  input  logic signed [2*DATA_W-1:0] prod,
  output logic signed [ACC_W-1:0]    sum,
  output logic                       ovf
);

  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] wide;

  // One guard bit is enough because the product always fits in ACC_W bits.
  assign wide = {acc[ACC_W-1], acc}
              + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_comb begin
    ovf = wide[ACC_W] ^ wide[ACC_W-1];
    sum = wide[ACC_W-1:0];
    if (ovf) begin
      sum = wide[ACC_W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/conv1_psum_accum.sv
// Layer-1 MAC: bias + TAPS int8 products; out_valid the cycle after the last beat.
// in_ready only in ACCUM; result held in DONE until out_ready, start ignored while busy.
module conv1_psum_accum
  import conv1_pkg::*;
#(
  parameter int TAPS   = CONV1_TAPS,
  parameter int DATA_W = CONV1_DATA_W,
  parameter int ACC_W  = CONV1_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  acc_data,
  output logic                     sat_flag,
  output logic                     busy
);

  localparam int CNT_W = $clog2(TAPS + 1);

  state_t                      state;
  logic signed [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]            count;
  logic                        sat;
  logic signed [2*DATA_W-1:0]  prod;
  logic signed [ACC_W-1:0]     sum;
  logic                        ovf;

  assign prod = pixel * weight;

  conv1_sat_add #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_sat_add (
    .acc  (acc),
    .prod (prod),
    .sum  (sum),
    .ovf  (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= bias;
            count <= '0;
            sat   <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc   <= sum;
            count <= count + CNT_W'(1);
            if (ovf) begin
              sat <= 1'b1;
            end
            if (count == CNT_W'(TAPS - 1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded straight from the registered state.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_data  = acc;
  assign sat_flag  = sat;

endmodule
